// File: rtl/arm_hazard_scoreboard_if.sv
// Decode-side request and hazard-control response bundle between the ARM core and its hazard scoreboard.
// The core drives the D-stage fields and reads back stalls, flushes, forwarding selects and counters.
interface arm_hazard_scoreboard_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
);
  logic              ValidD;
  logic [ADDR_W-1:0] RA1D;
  logic [ADDR_W-1:0] RA2D;
  logic              Use1D;
  logic              Use2D;
  logic [ADDR_W-1:0] WA3D;
  logic              RegWriteD;
  logic              MemToRegD;
  logic              PCSrcD;
  logic              BranchTakenE;

  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  modport master (
    output ValidD, RA1D, RA2D, Use1D, Use2D, WA3D,
    output RegWriteD, MemToRegD, PCSrcD, BranchTakenE,
    input  StallF, StallD, FlushD, FlushE,
    input  ForwardAE, ForwardBE, StallCount, FlushCount
  );

  modport slave (
    input  ValidD, RA1D, RA2D, Use1D, Use2D, WA3D,
    input  RegWriteD, MemToRegD, PCSrcD, BranchTakenE,
    output StallF, StallD, FlushD, FlushE,
    output ForwardAE, ForwardBE, StallCount, FlushCount
  );
endinterface

// File: rtl/arm_hazard_scoreboard.sv
// Hazard unit for the 5-stage ARM pipeline: shadows the E/M/W register tags and derives forwarding
// selects, load-use and PC-write stalls, branch flushes and saturating stall/flush counters.
module arm_hazard_scoreboard #(
  parameter int ADDR_W     = 4,
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 32
) (
  input logic                  clk,
  input logic                  reset,
  arm_hazard_scoreboard_if.slave hz
);

  localparam logic [ADDR_W-1:0] PC_REG = '1;

  logic              e_valid, e_use1, e_use2, e_regwrite, e_memtoreg, e_pcwr;
  logic [ADDR_W-1:0] e_ra1, e_ra2, e_wa;
  logic              m_valid, m_regwrite, m_pcwr;
  logic [ADDR_W-1:0] m_wa;
  logic              w_valid, w_regwrite, w_pcwr;
  logic [ADDR_W-1:0] w_wa;

  logic [CNT_W-1:0]  stall_count, flush_count;

  logic              d_rd1, d_rd2, e_rd1, e_rd2;
  logic              e_hit_d, m_hit_d, e_is_load;
  logic              ld_stall, pc_wr_pend, pc_src_w;
  logic              stall_f, stall_d, flush_d, flush_e;
  logic [1:0]        fwd_a, fwd_b;

  // R15 reads return PC+8 from the datapath, so a pending write to it never forwards or stalls.
  function automatic logic slot_match(input logic              valid,
                                      input logic              regwrite,
                                      input logic [ADDR_W-1:0] wa,
                                      input logic              rd_en,
                                      input logic [ADDR_W-1:0] ra);
    return valid & regwrite & rd_en & (wa == ra) & (ra != PC_REG);
  endfunction

  always_comb begin
    d_rd1     = hz.ValidD & hz.Use1D;
    d_rd2     = hz.ValidD & hz.Use2D;
    e_rd1     = e_valid & e_use1;
    e_rd2     = e_valid & e_use2;
    e_hit_d   = slot_match(e_valid, e_regwrite, e_wa, d_rd1, hz.RA1D) |
                slot_match(e_valid, e_regwrite, e_wa, d_rd2, hz.RA2D);
    m_hit_d   = slot_match(m_valid, m_regwrite, m_wa, d_rd1, hz.RA1D) |
                slot_match(m_valid, m_regwrite, m_wa, d_rd2, hz.RA2D);
    e_is_load = e_valid & e_memtoreg & e_regwrite;

    ld_stall = 1'b0;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    if (FORWARD_EN != 0) begin
      ld_stall = e_is_load & e_hit_d;
      if (slot_match(m_valid, m_regwrite, m_wa, e_rd1, e_ra1))      fwd_a = 2'b10;
      else if (slot_match(w_valid, w_regwrite, w_wa, e_rd1, e_ra1)) fwd_a = 2'b01;
      if (slot_match(m_valid, m_regwrite, m_wa, e_rd2, e_ra2))      fwd_b = 2'b10;
      else if (slot_match(w_valid, w_regwrite, w_wa, e_rd2, e_ra2)) fwd_b = 2'b01;
    end else begin
      ld_stall = e_hit_d | m_hit_d;
    end

    pc_wr_pend = (hz.ValidD & hz.PCSrcD) | (e_valid & e_pcwr) | (m_valid & m_pcwr);
    pc_src_w   = w_valid & w_pcwr;

    // Controls are held low during reset so the core cannot freeze or bubble on stale decode inputs.
    stall_f = ~reset & (ld_stall | pc_wr_pend);
    stall_d = ~reset & ld_stall;
    flush_d = ~reset & (pc_wr_pend | pc_src_w | hz.BranchTakenE);
    flush_e = ~reset & (ld_stall | hz.BranchTakenE);
    if (reset) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.StallCount = stall_count;
  assign hz.FlushCount = flush_count;

  // Tag fields need no reset: nothing reads them while the matching valid bit is clear.
  always_ff @(posedge clk) begin
    w_wa       <= m_wa;
    w_regwrite <= m_regwrite;
    w_pcwr     <= m_pcwr;
    m_wa       <= e_wa;
    m_regwrite <= e_regwrite;
    m_pcwr     <= e_pcwr;
    e_ra1      <= hz.RA1D;
    e_ra2      <= hz.RA2D;
    e_use1     <= hz.Use1D;
    e_use2     <= hz.Use2D;
    e_wa       <= hz.WA3D;
    e_regwrite <= hz.RegWriteD;
    e_memtoreg <= hz.MemToRegD;
    e_pcwr     <= hz.PCSrcD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid     <= 1'b0;
      m_valid     <= 1'b0;
      w_valid     <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      w_valid <= m_valid;
      m_valid <= e_valid;
      e_valid <= hz.ValidD & ~flush_e;
      if ((stall_f | stall_d) && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if ((flush_d | flush_e) && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Directed bench for arm_hazard_scoreboard: a forwarding instance with 4-bit counters and a
// stall-only instance share the same decode stream; each scenario is checked on the relevant one.
module tb_arm_hazard_scoreboard;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  arm_hazard_scoreboard_if #(.ADDR_W(4), .CNT_W(4))  hz_a ();
  arm_hazard_scoreboard_if #(.ADDR_W(4), .CNT_W(32)) hz_b ();

  arm_hazard_scoreboard #(.ADDR_W(4), .FORWARD_EN(1), .CNT_W(4)) u_dut_fwd (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_a)
  );

  arm_hazard_scoreboard #(.ADDR_W(4), .FORWARD_EN(0), .CNT_W(32)) u_dut_nofwd (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // One call is one clock cycle: inputs change on the falling edge, outputs settle 1 ns later.
  task automatic applyStimulus(input logic rst_in, input logic vd,
                               input logic [3:0] ra1, input logic [3:0] ra2,
                               input logic u1, input logic u2, input logic [3:0] wa,
                               input logic rw, input logic mtr, input logic pcs, input logic br);
    @(negedge clk);
    reset             = rst_in;
    hz_a.ValidD       = vd;   hz_b.ValidD       = vd;
    hz_a.RA1D         = ra1;  hz_b.RA1D         = ra1;
    hz_a.RA2D         = ra2;  hz_b.RA2D         = ra2;
    hz_a.Use1D        = u1;   hz_b.Use1D        = u1;
    hz_a.Use2D        = u2;   hz_b.Use2D        = u2;
    hz_a.WA3D         = wa;   hz_b.WA3D         = wa;
    hz_a.RegWriteD    = rw;   hz_b.RegWriteD    = rw;
    hz_a.MemToRegD    = mtr;  hz_b.MemToRegD    = mtr;
    hz_a.PCSrcD       = pcs;  hz_b.PCSrcD       = pcs;
    hz_a.BranchTakenE = br;   hz_b.BranchTakenE = br;
    #1;
  endtask

  task automatic op_nop();
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic op_alu(input logic [3:0] wa, input logic [3:0] ra1, input logic [3:0] ra2);
    applyStimulus(1'b0, 1'b1, ra1, ra2, 1'b1, 1'b1, wa, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic op_ldr(input logic [3:0] wa, input logic [3:0] ra1);
    applyStimulus(1'b0, 1'b1, ra1, 4'd0, 1'b1, 1'b0, wa, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic op_pc();
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b1;
    vectors     = 0;
    miscompares = 0;
    hz_a.ValidD = 1'b0; hz_a.RA1D = '0; hz_a.RA2D = '0; hz_a.Use1D = 1'b0; hz_a.Use2D = 1'b0;
    hz_a.WA3D = '0; hz_a.RegWriteD = 1'b0; hz_a.MemToRegD = 1'b0; hz_a.PCSrcD = 1'b0;
    hz_a.BranchTakenE = 1'b0;
    hz_b.ValidD = 1'b0; hz_b.RA1D = '0; hz_b.RA2D = '0; hz_b.Use1D = 1'b0; hz_b.Use2D = 1'b0;
    hz_b.WA3D = '0; hz_b.RegWriteD = 1'b0; hz_b.MemToRegD = 1'b0; hz_b.PCSrcD = 1'b0;
    hz_b.BranchTakenE = 1'b0;

    // Reset with a PC write and a taken branch on the inputs: every control stays low.
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_stall_f", 32'(hz_a.StallF), 32'd0);
    checkOutput("rst_stall_d", 32'(hz_a.StallD), 32'd0);
    checkOutput("rst_flush_d", 32'(hz_a.FlushD), 32'd0);
    checkOutput("rst_flush_e", 32'(hz_a.FlushE), 32'd0);
    op_nop();
    checkOutput("rst_stall_cnt", 32'(hz_a.StallCount), 32'd0);
    checkOutput("rst_flush_cnt", 32'(hz_a.FlushCount), 32'd0);

    // ADD R1,R2,R3 ; SUB R4,R1,R2 back to back -> SUB in E takes R1 from M.
    op_alu(4'd1, 4'd2, 4'd3);
    op_alu(4'd4, 4'd1, 4'd2);
    checkOutput("fwd_no_stall", 32'(hz_a.StallD), 32'd0);
    op_nop();
    checkOutput("fwd_m_a", 32'(hz_a.ForwardAE), 32'd2);
    checkOutput("fwd_m_b", 32'(hz_a.ForwardBE), 32'd0);

    // ADD R7 ; write R15 ; ADD R11,R7,R15 -> R7 from W, R15 never forwards even though M writes it.
    op_alu(4'd7, 4'd8, 4'd9);
    op_alu(4'd15, 4'd8, 4'd9);
    op_alu(4'd11, 4'd7, 4'd15);
    op_nop();
    checkOutput("fwd_w_a", 32'(hz_a.ForwardAE), 32'd1);
    checkOutput("fwd_r15_b", 32'(hz_a.ForwardBE), 32'd0);

    // LDR R2 ; ADD R3,R2,R2 -> one bubble, then both operands from W.
    do_reset();
    op_ldr(4'd2, 4'd0);
    op_alu(4'd3, 4'd2, 4'd2);
    checkOutput("ld_stall_f", 32'(hz_a.StallF), 32'd1);
    checkOutput("ld_stall_d", 32'(hz_a.StallD), 32'd1);
    checkOutput("ld_flush_e", 32'(hz_a.FlushE), 32'd1);
    checkOutput("ld_flush_d", 32'(hz_a.FlushD), 32'd0);
    op_alu(4'd3, 4'd2, 4'd2);
    checkOutput("ld_release_d", 32'(hz_a.StallD), 32'd0);
    checkOutput("ld_release_e", 32'(hz_a.FlushE), 32'd0);
    op_nop();
    checkOutput("ld_fwd_a", 32'(hz_a.ForwardAE), 32'd1);
    checkOutput("ld_fwd_b", 32'(hz_a.ForwardBE), 32'd1);
    checkOutput("ld_stall_cnt", 32'(hz_a.StallCount), 32'd1);
    checkOutput("ld_flush_cnt", 32'(hz_a.FlushCount), 32'd1);

    // Taken branch discards ADD R4 in D; a later R4 reader must not see it forwarded.
    do_reset();
    op_alu(4'd1, 4'd2, 4'd3);
    applyStimulus(1'b0, 1'b1, 4'd5, 4'd6, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("br_flush_d", 32'(hz_a.FlushD), 32'd1);
    checkOutput("br_flush_e", 32'(hz_a.FlushE), 32'd1);
    checkOutput("br_stall_f", 32'(hz_a.StallF), 32'd0);
    op_alu(4'd7, 4'd4, 4'd4);
    checkOutput("br_after_d", 32'(hz_a.FlushD), 32'd0);
    checkOutput("br_after_e", 32'(hz_a.FlushE), 32'd0);
    op_nop();
    checkOutput("br_e_empty_a", 32'(hz_a.ForwardAE), 32'd0);
    checkOutput("br_flush_cnt", 32'(hz_a.FlushCount), 32'd1);

    // Branch coinciding with a load-use: flush wins, no extra stall cycle afterwards.
    do_reset();
    op_ldr(4'd2, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("brld_flush_d", 32'(hz_a.FlushD), 32'd1);
    checkOutput("brld_flush_e", 32'(hz_a.FlushE), 32'd1);
    op_nop();
    checkOutput("brld_no_stall_f", 32'(hz_a.StallF), 32'd0);
    checkOutput("brld_no_stall_d", 32'(hz_a.StallD), 32'd0);

    // MOV R15: StallF for D/E/M, FlushD for D/E/M/W.
    do_reset();
    op_pc();
    checkOutput("pc_d_stall_f", 32'(hz_a.StallF), 32'd1);
    checkOutput("pc_d_flush_d", 32'(hz_a.FlushD), 32'd1);
    op_nop();
    checkOutput("pc_e_stall_f", 32'(hz_a.StallF), 32'd1);
    checkOutput("pc_e_flush_d", 32'(hz_a.FlushD), 32'd1);
    op_nop();
    checkOutput("pc_m_stall_f", 32'(hz_a.StallF), 32'd1);
    checkOutput("pc_m_flush_d", 32'(hz_a.FlushD), 32'd1);
    op_nop();
    checkOutput("pc_w_stall_f", 32'(hz_a.StallF), 32'd0);
    checkOutput("pc_w_flush_d", 32'(hz_a.FlushD), 32'd1);
    op_nop();
    checkOutput("pc_done_stall_f", 32'(hz_a.StallF), 32'd0);
    checkOutput("pc_done_flush_d", 32'(hz_a.FlushD), 32'd0);
    checkOutput("pc_stall_cnt", 32'(hz_a.StallCount), 32'd3);
    checkOutput("pc_flush_cnt", 32'(hz_a.FlushCount), 32'd4);

    // Stall-only instance: ADD R1 ; ADD R5,R1,R1 stalls while R1 sits in E then M.
    do_reset();
    op_alu(4'd1, 4'd2, 4'd3);
    op_alu(4'd5, 4'd1, 4'd1);
    checkOutput("nf_stall_e", 32'(hz_b.StallD), 32'd1);
    checkOutput("nf_fwd_a", 32'(hz_b.ForwardAE), 32'd0);
    op_alu(4'd5, 4'd1, 4'd1);
    checkOutput("nf_stall_m", 32'(hz_b.StallD), 32'd1);
    checkOutput("nf_fwd_b", 32'(hz_b.ForwardBE), 32'd0);
    op_alu(4'd5, 4'd1, 4'd1);
    checkOutput("nf_release", 32'(hz_b.StallD), 32'd0);
    op_nop();
    checkOutput("nf_fwd_a_end", 32'(hz_b.ForwardAE), 32'd0);
    checkOutput("nf_stall_cnt", 32'(hz_b.StallCount), 32'd2);

    // 4-bit counters: 20 PC-write stall cycles saturate at 15.
    do_reset();
    for (int i = 0; i < 15; i++) op_pc();
    op_pc();
    checkOutput("sat_stall_15", 32'(hz_a.StallCount), 32'd15);
    for (int i = 0; i < 4; i++) op_pc();
    op_nop();
    checkOutput("sat_stall_hold", 32'(hz_a.StallCount), 32'd15);
    checkOutput("sat_flush_hold", 32'(hz_a.FlushCount), 32'd15);

    // Reset during an active load-use stall.
    do_reset();
    op_ldr(4'd2, 4'd0);
    applyStimulus(1'b1, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid_stall_f", 32'(hz_a.StallF), 32'd0);
    checkOutput("rstmid_stall_d", 32'(hz_a.StallD), 32'd0);
    checkOutput("rstmid_flush_e", 32'(hz_a.FlushE), 32'd0);
    op_alu(4'd3, 4'd2, 4'd2);
    checkOutput("rstmid_after_a", 32'(hz_a.StallD), 32'd0);
    checkOutput("rstmid_after_b", 32'(hz_b.StallD), 32'd0);
    checkOutput("rstmid_stall_cnt", 32'(hz_a.StallCount), 32'd0);
    checkOutput("rstmid_flush_cnt", 32'(hz_a.FlushCount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
